mem_access: RTL
===============

Name: mem_access

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of writeback.
- Takes the registered ALU result, opcode and store data from execute. Passes non-memory results through in one cycle.
- For loads and stores, runs a single-outstanding request/acknowledge transaction with data memory. Handles byte lanes, alignment checking and load sign/zero extension.
- Stalls execute while a transaction is in flight.

Parameters:
- OPC_LOAD, 5'b00000, opcode value (instr[6:2]) identifying loads
- OPC_STORE, 5'b01000, opcode value identifying stores

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  execute presents a valid instruction this cycle
- opcode_i  input  5  opcode from execute
- funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_i  input  32  ALU result; the effective address for loads/stores
- store_data_i  input  32  rs2 value for stores
- rd_addr_i  input  5  destination register index
- stall_o  output  1  execute must hold its outputs this cycle
- mem_req_o  output  1  memory request valid
- mem_we_o  output  1  1 = store, 0 = load
- mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  32  lane-replicated store data
- mem_ack_i  input  1  memory completes the request (rdata valid this cycle for loads)
- mem_rdata_i  input  32  load data word
- valid_o  output  1  result valid to writeback, one-cycle pulse per instruction
- opcode_o  output  5  opcode of the retiring instruction
- rd_addr_o  output  5  destination register index
- wb_en_o  output  1  writeback should write rd
- wb_data_o  output  32  writeback data
- err_o  output  1  access fault (misaligned or illegal funct3)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. All outputs are 0: valid_o, opcode_o, rd_addr_o, wb_en_o, wb_data_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o.
- Reset asserted during ACCESS: the state returns to IDLE and mem_req_o drops at the next edge; the instruction is discarded with no valid_o. A late mem_ack_i is ignored.
- States: IDLE and ACCESS. stall_o = (state==ACCESS), combinational.
- Accept: an instruction is accepted only in IDLE with valid_i=1. In ACCESS, inputs are ignored; upstream holds them.
- Non-memory op accepted at cycle T, at T+1:
  - valid_o=1, wb_data_o=alu_result_i, opcode_o and rd_addr_o copied
  - wb_en_o=(rd_addr_i!=0), err_o=0
  - Back-to-back non-memory ops give full throughput.
- Memory op accepted at T:
  - Illegal funct3, or a misaligned address, causes a fault. Load illegal funct3 is 011, 110 or 111; store illegal funct3 is anything other than 000, 001 or 010. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Fault response at T+1: valid_o=1, err_o=1, wb_en_o=0, wb_data_o=0. No memory request is issued and the state stays IDLE.
  - Otherwise, at T+1: state=ACCESS. The registered mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are valid and stay stable until ack.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << addr[1:0]
  - W: 4'b1111
  - Loads drive the same byte-enable pattern.
- Store data replication:
  - B: {4{sd[7:0]}}
  - H: {2{sd[15:0]}}
  - W: sd
- In ACCESS, the first cycle with mem_ack_i=1 (cycle T+k, k>=1) completes the transaction. At T+k+1:
  - state=IDLE, mem_req_o=0, valid_o=1, err_o=0
  - Load: lane = mem_rdata_i >> (8*addr[1:0]). B and H are sign-extended from bit 7 or 15. BU and HU are zero-extended. W is used as-is. wb_en_o=(rd!=0).
  - Store: wb_en_o=0 and wb_data_o=0.
- mem_ack_i is ignored outside ACCESS. An ack in the same cycle as a request is impossible because the request is registered, so the minimum k is 1.
- A new instruction can be accepted at T+k+1. Memory-op occupancy is k+1 cycles.
- valid_o is 0 on every cycle without a retiring instruction. The other outputs hold their last values except mem_req_o.

Test Plan:
- Reset then ALU op: valid_i=1, opcode=5'b00100, alu_result_i=0x0000_1234, rd=5 -> next cycle valid_o=1, wb_data_o=0x1234, wb_en_o=1, stall_o=0.
- LB at addr 0x103, rdata=0x80AA_BBCC, ack after 3 request cycles -> mem_addr_o=0x100, be=4'b1000, stall_o high 3 cycles, then wb_data_o=0xFFFF_FF80.
- LHU at 0x202, rdata=0x8001_0000, ack after 1 cycle -> be=4'b1100, wb_data_o=0x0000_8001.
- SH at 0x002, store_data=0xDEAD_BEEF -> mem_we_o=1, be=4'b1100, wdata=0xBEEF_BEEF, on retire wb_en_o=0.
- LW at 0x101 -> no mem_req_o, next cycle valid_o=1, err_o=1, wb_en_o=0. LB with rd=0 -> wb_en_o=0.
- LW at 0x40, rst pulsed while waiting for ack -> mem_req_o=0 next cycle, no valid_o, and a later ack is ignored.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage: ALU pass-through, load/store handshake, lane and extension logic
module mem_access #(
  parameter logic [4:0] OPC_LOAD  = 5'b00000,
  parameter logic [4:0] OPC_STORE = 5'b01000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic [4:0]  opcode_o,
  output logic [4:0]  rd_addr_o,
  output logic        wb_en_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_next;

  logic        is_load, is_store, is_mem, illegal, misaligned, fault, accept;
  logic [3:0]  be;
  logic [31:0] wdata, lane, load_data;

  // Instruction context held while the transaction is in flight
  logic [4:0]  opcode_q, rd_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  assign is_load  = (opcode_i == OPC_LOAD);
  assign is_store = (opcode_i == OPC_STORE);
  assign is_mem   = is_load | is_store;
  assign accept   = (state == IDLE) & valid_i;
  assign stall_o  = (state == ACCESS);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = store_data_i;
    if (is_load)
      illegal = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111);
    else
      illegal = funct3_i[2] | (funct3_i == 3'b011);
    case (funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << alu_result_i[1:0];
        wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << alu_result_i[1:0];
        wdata      = {2{store_data_i[15:0]}};
        misaligned = alu_result_i[0];
      end
      default: misaligned = (alu_result_i[1:0] != 2'b00);
    endcase
    fault = illegal | misaligned;
  end

  always_comb begin
    lane      = mem_rdata_i >> {addr_lo_q, 3'b000};
    load_data = lane;
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !fault) state_next = ACCESS;
      ACCESS:  if (mem_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      opcode_o    <= 5'd0;
      rd_addr_o   <= 5'd0;
      wb_en_o     <= 1'b0;
      wb_data_o   <= 32'd0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
      opcode_q    <= 5'd0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          valid_o   <= 1'b1;
          opcode_o  <= opcode_i;
          rd_addr_o <= rd_addr_i;
          wb_en_o   <= (rd_addr_i != 5'd0);
          wb_data_o <= alu_result_i;
          err_o     <= 1'b0;
        end else if (fault) begin
          valid_o   <= 1'b1;
          opcode_o  <= opcode_i;
          rd_addr_o <= rd_addr_i;
          wb_en_o   <= 1'b0;
          wb_data_o <= 32'd0;
          err_o     <= 1'b1;
        end else begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= is_store;
          mem_addr_o  <= {alu_result_i[31:2], 2'b00};
          mem_be_o    <= be;
          mem_wdata_o <= wdata;
          opcode_q    <= opcode_i;
          rd_q        <= rd_addr_i;
          funct3_q    <= funct3_i;
          addr_lo_q   <= alu_result_i[1:0];
        end
      end else if (state == ACCESS && mem_ack_i) begin
        mem_req_o <= 1'b0;
        valid_o   <= 1'b1;
        err_o     <= 1'b0;
        opcode_o  <= opcode_q;
        rd_addr_o <= rd_q;
        if (mem_we_o) begin
          wb_en_o   <= 1'b0;
          wb_data_o <= 32'd0;
        end else begin
          wb_en_o   <= (rd_q != 5'd0);
          wb_data_o <= load_data;
        end
      end
    end
  end

endmodule
